mips_regfile_onehot: RTL

- 32-entry general-purpose register file for the MIPS datapath.
- Sits directly downstream of the 5-to-32 write-address decoder and consumes its one-hot output as the write-row select.
- Two combinational read ports and one synchronous write port.
- Register $0 is hardwired to zero; a registered error flag reports malformed write selects.

---
 rtl/mips_pkg.sv | 14 +
 rtl/mips_regfile_rdport.sv | 29 ++
 rtl/mips_regfile_onehot.sv | 88 ++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

    localparam int NREGS      = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // Register $0 always reads as zero and ignores writes.
    localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/mips_regfile_rdport.sv
// One combinational read port: row mux, $0 forcing and optional write-first bypass.
// Latency: zero (pure combinational).
// Backpressure: none; always produces data for the presented address.
module mips_regfile_rdport
    import mips_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int BYPASS = 1
) (
    input  logic [REG_ADDR_W-1:0]        ra_i,
    input  logic [NREGS-1:0][WIDTH-1:0]  regs_i,
    input  logic [NREGS-1:0]             wsel_i,
    input  logic                         we3_i,
    input  logic [WIDTH-1:0]             wd3_i,
    input  logic                         wsel_vld_i,
    output logic [WIDTH-1:0]             rd_o
);

    // $0 wins over everything; otherwise a same-cycle valid write to this row is forwarded.
    always_comb begin
        rd_o = regs_i[ra_i];
        if (ra_i == ZERO_REG) begin
            rd_o = '0;
        end else if ((BYPASS != 0) && we3_i && wsel_vld_i && wsel_i[ra_i]) begin
            rd_o = wd3_i;
        end
    end

endmodule

// File: rtl/mips_regfile_onehot.sv
// 32x WIDTH register file, one-hot write select, two combinational read ports.
// Latency: reads zero cycles, writes visible next cycle (same cycle with bypass), wr_err one cycle.
// Backpressure: none; malformed write selects are dropped and flagged on wr_err.
module mips_regfile_onehot
    import mips_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int BYPASS = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we3,
    input  logic [NREGS-1:0]       wsel,
    input  logic [WIDTH-1:0]       wd3,
    input  logic [REG_ADDR_W-1:0]  ra1,
    input  logic [REG_ADDR_W-1:0]  ra2,
    output logic [WIDTH-1:0]       rd1,
    output logic [WIDTH-1:0]       rd2,
    output logic                   wr_err
);

    logic [NREGS-1:0][WIDTH-1:0] regs_q;
    logic [NREGS-1:0][WIDTH-1:0] regs_d;
    logic                        wr_err_q;
    logic                        wr_err_d;
    logic                        wsel_vld;

    // Exactly-one-bit test; written as if/else so an unknown select falls to "not valid".
    always_comb begin
        wsel_vld = 1'b0;
        if ((wsel != '0) && ((wsel & (wsel - NREGS'(1))) == '0)) begin
            wsel_vld = 1'b1;
        end
    end

    // Next state: write the selected row (never $0) and flag rejected writes.
    always_comb begin
        regs_d   = regs_q;
        wr_err_d = we3 && !wsel_vld;
        if (we3 && wsel_vld) begin
            for (int i = 0; i < NREGS; i++) begin
                if (wsel[i] && (i != int'(ZERO_REG))) begin
                    regs_d[i] = wd3;
                end
            end
        end
    end

    // Flop array so a synchronous reset clears every row in a single cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q   <= '0;
            wr_err_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign wr_err = wr_err_q;

    mips_regfile_rdport #(
        .WIDTH  (WIDTH),
        .BYPASS (BYPASS)
    ) u_rdport1 (
        .ra_i       (ra1),
        .regs_i     (regs_q),
        .wsel_i     (wsel),
        .we3_i      (we3),
        .wd3_i      (wd3),
        .wsel_vld_i (wsel_vld),
        .rd_o       (rd1)
    );

    mips_regfile_rdport #(
        .WIDTH  (WIDTH),
        .BYPASS (BYPASS)
    ) u_rdport2 (
        .ra_i       (ra2),
        .regs_i     (regs_q),
        .wsel_i     (wsel),
        .we3_i      (we3),
        .wd3_i      (wd3),
        .wsel_vld_i (wsel_vld),
        .rd_o       (rd2)
    );

endmodule
